// File: rtl/ty_axis_pkg.sv
// ty_axis_pkg: shared constants and helpers for the ty_axis_join slice.
//   TY_MAX_CHANNELS    - upper bound on joined channels
//   TY_MAX_DATA_WIDTH  - upper bound on one channel beat width
//   ty_ptr_width()     - width of FIFO pointers/counts (one extra bit so a
//                        full FIFO's count of C_DEPTH is representable)
package ty_axis_pkg;

  localparam int TY_MAX_CHANNELS   = 8;
  localparam int TY_MAX_DATA_WIDTH = 512;

  function automatic int ty_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ty_axis_join_if.sv
// ty_axis_join_if: bundle of the per-channel input streams, the joined
// output stream and the occupancy debug bus.
//   slave  - view of the join block (consumes s_*, m_tready; drives the rest)
//   master - view of the surrounding logic (sources s_*, sinks m_*)
interface ty_axis_join_if #(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_NUM_CHANNELS = 2,
  parameter int C_DEPTH        = 4
);

  logic [C_NUM_CHANNELS-1:0]                        s_tvalid;
  logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]      s_tdata;
  logic [C_NUM_CHANNELS-1:0]                        s_tready;
  logic                                             m_tvalid;
  logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]      m_tdata;
  logic                                             m_tready;
  logic [C_NUM_CHANNELS-1:0][$clog2(C_DEPTH):0]     m_occupancy;

  modport slave (
    input  s_tvalid, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tdata, m_occupancy
  );

  modport master (
    output s_tvalid, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_occupancy
  );

endinterface

// File: rtl/ty_axis_fifo.sv
// ty_axis_fifo: single-channel FIFO used by ty_axis_join.
//   aclk/areset - clock, asynchronous active-high reset (clears storage too)
//   push        - write push_data (ignored when full)
//   pop         - advance the head (ignored when empty)
//   head_data   - combinational read of the entry at the read pointer
//   full/empty  - count == C_DEPTH / count == 0
//   count       - number of stored entries
module ty_axis_fifo
  import ty_axis_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_DEPTH      = 4
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       push,
  input  logic [C_DATA_WIDTH-1:0]    push_data,
  input  logic                       pop,
  output logic [C_DATA_WIDTH-1:0]    head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(C_DEPTH):0]   count
);

  localparam int PTR_W = ty_ptr_width(C_DEPTH);
  localparam int IDX_W = $clog2(C_DEPTH);

  typedef logic [C_DATA_WIDTH-1:0] ty_beat_t;

  ty_beat_t          mem_q [C_DEPTH];
  ty_beat_t          mem_d [C_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full      = (count_q == PTR_W'(C_DEPTH));
  assign empty     = (count_q == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign count     = count_q;
  // Pointers run over 2*C_DEPTH; only the low bits address storage.
  assign head_data = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Count is kept separately; a simultaneous push and pop leaves it alone.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + PTR_W'(1);
      2'b01:   count_d = count_q - PTR_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ty_axis_join.sv
// ty_axis_join: per-channel elastic input stage that joins C_NUM_CHANNELS
// independent AXI4-Stream inputs into one aligned, all-valid stream.
//   aclk   - single clock, rising edge
//   areset - asynchronous active-high reset; discards all buffered beats
//   axis   - ty_axis_join_if.slave: s_tvalid/s_tdata/s_tready per channel,
//            joined m_tvalid/m_tdata/m_tready, per-channel m_occupancy
// Each channel has its own FIFO; the joined beat is valid only when every
// FIFO holds data, and all FIFOs pop together so beats pair by arrival index.
module ty_axis_join
  import ty_axis_pkg::*;
#(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_NUM_CHANNELS = 2,
  parameter int C_DEPTH        = 4
) (
  input  logic           aclk,
  input  logic           areset,
  ty_axis_join_if.slave  axis
);

  if (C_NUM_CHANNELS < 1 || C_NUM_CHANNELS > TY_MAX_CHANNELS) begin : g_bad_channels
    $error("ty_axis_join: C_NUM_CHANNELS out of range");
  end
  if (C_DATA_WIDTH < 1 || C_DATA_WIDTH > TY_MAX_DATA_WIDTH) begin : g_bad_width
    $error("ty_axis_join: C_DATA_WIDTH out of range");
  end
  if (C_DEPTH < 2 || (C_DEPTH & (C_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ty_axis_join: C_DEPTH must be a power of two >= 2");
  end

  logic [C_NUM_CHANNELS-1:0] push;
  logic [C_NUM_CHANNELS-1:0] full;
  logic [C_NUM_CHANNELS-1:0] empty;
  logic                      pop;

  generate
    for (genvar gi = 0; gi < C_NUM_CHANNELS; gi++) begin : g_ch
      // Ready depends only on local state and reset: a full channel stays
      // not-ready even in a cycle where the shared pop frees an entry.
      assign axis.s_tready[gi] = !full[gi] && !areset;
      assign push[gi]          = axis.s_tvalid[gi] && axis.s_tready[gi];

      ty_axis_fifo #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_DEPTH      (C_DEPTH)
      ) u_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .push      (push[gi]),
        .push_data (axis.s_tdata[gi]),
        .pop       (pop),
        .head_data (axis.m_tdata[gi]),
        .full      (full[gi]),
        .empty     (empty[gi]),
        .count     (axis.m_occupancy[gi])
      );
    end
  endgenerate

  // Join: valid only when every channel holds its next beat.
  assign axis.m_tvalid = ~|empty;
  // Shared pop keeps the channels paired by arrival index.
  assign pop = axis.m_tvalid && axis.m_tready;

endmodule

// File: tb/tb_ty_axis_join.sv
// tb_ty_axis_join: scoreboard bench for ty_axis_join (2 channels, depth 4).
// Stimulus pushes expected joined beats into exp_q (hand-computed in the
// directed phases, paired from accepted inputs in the streaming phases);
// a negedge monitor pops and compares whenever a joined beat is taken.
module tb_ty_axis_join;

  localparam int DW  = 32;
  localparam int NC  = 2;
  localparam int DEP = 4;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic tv0 = 1'b1, tv1 = 1'b1;
  logic [DW-1:0] td0 = 32'hDEAD_0000, td1 = 32'hDEAD_0001;
  logic rdy = 1'b1;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  bit auto_pair = 1'b0;

  logic [2*DW-1:0] exp_q[$];
  logic [DW-1:0]   ch0_q[$];
  logic [DW-1:0]   ch1_q[$];

  always #5 aclk = ~aclk;

  ty_axis_join_if #(.C_DATA_WIDTH(DW), .C_NUM_CHANNELS(NC), .C_DEPTH(DEP)) bus ();

  assign bus.s_tvalid   = {tv1, tv0};
  assign bus.s_tdata[0] = td0;
  assign bus.s_tdata[1] = td1;
  assign bus.m_tready   = rdy;

  ty_axis_join #(.C_DATA_WIDTH(DW), .C_NUM_CHANNELS(NC), .C_DEPTH(DEP)) dut (
    .aclk   (aclk),
    .areset (areset),
    .axis   (bus)
  );

  task automatic chk(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Offer one beat on a channel and hold it until accepted (bounded).
  task automatic send_one(input int ch, input logic [DW-1:0] d);
    logic acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    if (ch == 0) begin tv0 = 1'b1; td0 = d; end
    else         begin tv1 = 1'b1; td1 = d; end
    while (!acc && guard < 50) begin
      @(negedge aclk);
      acc = bus.s_tready[ch];
      tick();
      guard++;
    end
    if (ch == 0) tv0 = 1'b0; else tv1 = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout ch %0d actual not_accepted required accepted", ch);
    end
  endtask

  task automatic stream_ch(input int ch);
    int sent;
    int guard;
    logic [DW-1:0] d;
    logic v, acc;
    sent = 0;
    guard = 0;
    d = $urandom;
    while (sent < 1000 && guard < 20000) begin
      v = 1'($urandom_range(0, 1));
      if (ch == 0) begin tv0 = v; td0 = d; end
      else         begin tv1 = v; td1 = d; end
      @(negedge aclk);
      acc = v && bus.s_tready[ch];
      tick();
      if (acc) begin
        sent++;
        d = $urandom;
      end
      guard++;
    end
    if (ch == 0) tv0 = 1'b0; else tv1 = 1'b0;
    chk($sformatf("stream_sent_ch%0d", ch), 64'(sent), 64'd1000);
  endtask

  // Monitor / scoreboard.
  always @(negedge aclk) begin
    logic [2*DW-1:0] e;
    if (!areset) begin
      if (bus.m_tvalid && bus.m_tready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual %h required none", bus.m_tdata);
        end else begin
          e = exp_q.pop_front();
          $display("beat %0d data %h expected %h", out_cnt, bus.m_tdata, e);
          chk("joined_beat", bus.m_tdata, e);
        end
      end
      if (auto_pair) begin
        if (bus.s_tvalid[0] && bus.s_tready[0]) ch0_q.push_back(bus.s_tdata[0]);
        if (bus.s_tvalid[1] && bus.s_tready[1]) ch1_q.push_back(bus.s_tdata[1]);
        while (ch0_q.size() > 0 && ch1_q.size() > 0) begin
          exp_q.push_back({ch1_q.pop_front(), ch0_q.pop_front()});
        end
      end
      chk("occ_max_ch0", 64'(bus.m_occupancy[0] > 3'd4), 64'd0);
      chk("occ_max_ch1", 64'(bus.m_occupancy[1] > 3'd4), 64'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stream_done;
    int guard;

    // Reset held with both channels offering data.
    repeat (3) begin
      @(negedge aclk);
      chk("rst_s_tready", 64'(bus.s_tready), 64'd0);
      chk("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
      chk("rst_m_tdata", bus.m_tdata, 64'd0);
      chk("rst_occ", 64'(bus.m_occupancy), 64'd0);
    end
    @(posedge aclk);
    #1;
    areset = 1'b0;
    tv0 = 1'b0;
    tv1 = 1'b0;
    #1;
    chk("rel_s_tready", 64'(bus.s_tready), 64'd3);

    // Skewed arrival: ch0 first, ch1 three cycles later.
    rdy = 1'b1;
    exp_q.push_back({32'hA0, 32'h10});
    exp_q.push_back({32'hA1, 32'h11});
    exp_q.push_back({32'hA2, 32'h12});
    send_one(0, 32'h10);
    send_one(0, 32'h11);
    send_one(0, 32'h12);
    chk("skew_occ_ch0", 64'(bus.m_occupancy[0]), 64'd3);
    chk("skew_valid_before", 64'(bus.m_tvalid), 64'd0);
    send_one(1, 32'hA0);
    chk("skew_first_valid", 64'(bus.m_tvalid), 64'd1);
    chk("skew_first_data", bus.m_tdata, {32'hA0, 32'h10});
    send_one(1, 32'hA1);
    send_one(1, 32'hA2);
    repeat (3) tick();
    chk("skew_drained", 64'(exp_q.size()), 64'd0);
    chk("skew_occ_end", 64'(bus.m_occupancy), 64'd0);

    // Full channel: ch0 fills, 5th beat waits for the first pop.
    rdy = 1'b0;
    exp_q.push_back({32'hB0, 32'h20});
    exp_q.push_back({32'hB1, 32'h21});
    exp_q.push_back({32'hB2, 32'h22});
    exp_q.push_back({32'hB3, 32'h23});
    exp_q.push_back({32'hB4, 32'h24});
    for (int k = 0; k < 4; k++) send_one(0, 32'h20 + 32'(k));
    chk("full_ready_low", 64'(bus.s_tready[0]), 64'd0);
    chk("full_occ4", 64'(bus.m_occupancy[0]), 64'd4);
    fork
      send_one(0, 32'h24);
      begin
        repeat (3) tick();
        chk("full_held_occ", 64'(bus.m_occupancy[0]), 64'd4);
        send_one(1, 32'hB0);
        chk("full_join_valid", 64'(bus.m_tvalid), 64'd1);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("full_no_bypass", 64'(bus.m_occupancy[0]), 64'd3);
      end
    join
    chk("full_fifth_in", 64'(bus.m_occupancy[0]), 64'd4);
    rdy = 1'b1;
    for (int k = 1; k < 5; k++) send_one(1, 32'hB0 + 32'(k));
    repeat (3) tick();
    chk("full_drained", 64'(exp_q.size()), 64'd0);
    chk("full_occ_end", 64'(bus.m_occupancy), 64'd0);

    // Stall stability: head must hold while pushes continue.
    rdy = 1'b0;
    exp_q.push_back({32'h40, 32'h30});
    exp_q.push_back({32'h41, 32'h31});
    exp_q.push_back({32'h42, 32'h32});
    exp_q.push_back({32'h43, 32'h33});
    send_one(0, 32'h30);
    send_one(1, 32'h40);
    for (int k = 0; k < 4; k++) begin
      tv0 = 1'b1; td0 = 32'h31 + 32'(k);
      tv1 = 1'b1; td1 = 32'h41 + 32'(k);
      tick();
      chk("stall_valid", 64'(bus.m_tvalid), 64'd1);
      chk("stall_data", bus.m_tdata, {32'h40, 32'h30});
    end
    tv0 = 1'b0;
    tv1 = 1'b0;
    chk("stall_occ", 64'(bus.m_occupancy), {58'd0, 3'd4, 3'd4});
    rdy = 1'b1;
    repeat (6) tick();
    chk("stall_drained", 64'(exp_q.size()), 64'd0);

    // Random streaming, paired by arrival index.
    auto_pair = 1'b1;
    out_cnt = 0;
    stream_done = 1'b0;
    fork
      begin
        fork
          stream_ch(0);
          stream_ch(1);
        join
        stream_done = 1'b1;
      end
      begin
        guard = 0;
        while (!stream_done && guard < 40000) begin
          rdy = 1'($urandom_range(0, 1));
          tick();
          guard++;
        end
      end
    join
    rdy = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      tick();
      guard++;
    end
    chk("stream_drained", 64'(exp_q.size()), 64'd0);
    chk("stream_out_cnt", 64'(out_cnt), 64'd1000);

    // Reset mid-operation with occupancy {3,1}.
    rdy = 1'b0;
    send_one(1, 32'h70);
    send_one(1, 32'h71);
    send_one(1, 32'h72);
    send_one(0, 32'h60);
    chk("mid_occ_pre", 64'(bus.m_occupancy), {58'd0, 3'd3, 3'd1});
    @(posedge aclk);
    #3;
    areset = 1'b1;
    exp_q.delete();
    ch0_q.delete();
    ch1_q.delete();
    #1;
    chk("mid_occ_rst", 64'(bus.m_occupancy), 64'd0);
    chk("mid_valid_rst", 64'(bus.m_tvalid), 64'd0);
    chk("mid_ready_rst", 64'(bus.s_tready), 64'd0);
    chk("mid_data_rst", bus.m_tdata, 64'd0);
    repeat (2) @(posedge aclk);
    #3;
    areset = 1'b0;
    #1;
    chk("mid_ready_rel", 64'(bus.s_tready), 64'd3);
    rdy = 1'b1;
    send_one(0, 32'h80);
    chk("mid_no_partial", 64'(bus.m_tvalid), 64'd0);
    send_one(1, 32'h90);
    chk("mid_post_valid", 64'(bus.m_tvalid), 64'd1);
    chk("mid_post_data", bus.m_tdata, {32'h90, 32'h80});
    repeat (3) tick();
    chk("mid_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
